// File: rtl/x25519_pkg.sv
// rtl/x25519_pkg.sv - shared types, constants and scalar clamp for the X25519 ladder sequencer
package x25519_pkg;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } ladder_state_t;

    localparam logic [511:0] XZ_INIT_M = {256'h0, 256'h1};
    localparam logic [255:0] Z_ONE     = 256'h1;

    function automatic logic [255:0] clamp_scalar(input logic [255:0] s);
        logic [255:0] r;
        r      = s;
        r[2:0] = 3'b000;
        r[255] = 1'b0;
        r[254] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/x25519_ladder_sequencer.sv
// rtl/x25519_ladder_sequencer.sv - drives one ladder iteration per scalar bit and returns projective (x, z)
module x25519_ladder_sequencer
    import x25519_pkg::*;
#(
    parameter int CLAMP_SCALAR = 1,
    parameter int FIRST_BIT    = 254,
    parameter int FLUSH_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] scalar_in,
    input  logic [255:0] u_in,
    output logic         busy,
    output logic         done,
    output logic [511:0] result_xz,
    output logic         iter_en,
    output logic [511:0] iter_xzm,
    output logic [511:0] iter_xzm1,
    output logic         iter_b,
    output logic [263:0] iter_work_low,
    input  logic         iter_valid,
    input  logic [511:0] iter_xzm_out,
    input  logic [511:0] iter_xzm1_out
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    ladder_state_t state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [7:0]       pos_q, pos_d;
    logic [255:0]     k_q, k_d;
    logic             done_q, done_d;
    logic             iter_en_q, iter_en_d;
    logic             iter_b_q, iter_b_d;
    logic [511:0]     result_q, result_d;
    logic [511:0]     xzm_q, xzm_d;
    logic [511:0]     xzm1_q, xzm1_d;
    logic [263:0]     work_low_q, work_low_d;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pos_d       = pos_q;
        k_d         = k_q;
        done_d      = 1'b0;
        iter_en_d   = 1'b0;
        iter_b_d    = iter_b_q;
        result_d    = result_q;
        xzm_d       = xzm_q;
        xzm1_d      = xzm1_q;
        work_low_d  = work_low_q;
        case (state_q)
            // The iteration unit has no reset; wait out any iteration it may still finish.
            FLUSH: begin
                if (flush_cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (start) begin
                    k_d        = (CLAMP_SCALAR != 0) ? clamp_scalar(scalar_in) : scalar_in;
                    work_low_d = {8'h0, 1'b0, u_in[254:0]};
                    xzm_d      = XZ_INIT_M;
                    xzm1_d     = {Z_ONE, 1'b0, u_in[254:0]};
                    pos_d      = 8'(FIRST_BIT);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                iter_en_d = 1'b1;
                iter_b_d  = k_q[pos_q];
                state_d   = WAIT;
            end
            WAIT: begin
                if (iter_valid) begin
                    xzm_d  = iter_xzm_out;
                    xzm1_d = iter_xzm1_out;
                    if (pos_q == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        pos_d   = pos_q - 8'd1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                result_d = xzm_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
            pos_q       <= '0;
            k_q         <= '0;
            done_q      <= 1'b0;
            iter_en_q   <= 1'b0;
            iter_b_q    <= 1'b0;
            result_q    <= '0;
            xzm_q       <= '0;
            xzm1_q      <= '0;
            work_low_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pos_q       <= pos_d;
            k_q         <= k_d;
            done_q      <= done_d;
            iter_en_q   <= iter_en_d;
            iter_b_q    <= iter_b_d;
            result_q    <= result_d;
            xzm_q       <= xzm_d;
            xzm1_q      <= xzm1_d;
            work_low_q  <= work_low_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign result_xz     = result_q;
    assign iter_en       = iter_en_q;
    assign iter_b        = iter_b_q;
    assign iter_xzm      = xzm_q;
    assign iter_xzm1     = xzm1_q;
    assign iter_work_low = work_low_q;

endmodule
